// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory addressing and the IF/ID pipeline register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int          N         = 64,
    parameter logic [31:0] NOP_INSTR = 32'h8b1f03ff
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          PCSrc,
    input  logic [N-1:0]  PCBranch,
    output logic [6:0]    imem_addr,
    input  logic [31:0]   imem_q,
    output logic [N-1:0]  pc_F,
    output logic [N-1:0]  IF_ID_pc,
    output logic [31:0]   IF_ID_instr,
    output logic          IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_stall_cnt
`endif
);

    localparam logic [N-1:0] PC_STEP = N'(4);

    logic [N-1:0] pc_next;
    logic         squash;
    logic         fetch_load;

    assign imem_addr  = pc_F[8:2];
    assign squash     = flush | PCSrc;
    assign fetch_load = ~squash & ~stall;

    // Redirect wins over stall; branch targets are forced word-aligned.
    always_comb begin
        pc_next = pc_F;
        if (PCSrc) begin
            pc_next = {PCBranch[N-1:2], 2'b00};
        end else if (!stall) begin
            pc_next = pc_F + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_F        <= '0;
            IF_ID_pc    <= '0;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end else begin
            pc_F <= pc_next;
            if (squash) begin
                IF_ID_pc    <= '0;
                IF_ID_instr <= NOP_INSTR;
                IF_ID_valid <= 1'b0;
            end else if (fetch_load) begin
                IF_ID_pc    <= pc_F;
                IF_ID_instr <= imem_q;
                IF_ID_valid <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_load && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (stall && !PCSrc && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a behavioural model.
// Perf-counter checks compile in only when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h8b1f03ff;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, pcsrc;
    logic [63:0] pcbranch;
    logic [6:0]  imem_addr;
    logic [31:0] imem_q;
    logic [63:0] pc_F, IF_ID_pc;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    logic [31:0] mem [128];
    assign imem_q = mem[imem_addr];

    // Behavioural model state
    logic [63:0] m_pc, m_ifpc;
    logic [31:0] m_instr;
    logic        m_valid;
    longint unsigned m_fetch, m_stall;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    fetch_stage #(.N(64), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .PCSrc(pcsrc),
        .PCBranch(pcbranch), .imem_addr(imem_addr), .imem_q(imem_q), .pc_F(pc_F),
        .IF_ID_pc(IF_ID_pc), .IF_ID_instr(IF_ID_instr), .IF_ID_valid(IF_ID_valid)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    task automatic model_reset();
        m_pc = '0; m_ifpc = '0; m_instr = NOP; m_valid = 1'b0; m_fetch = 0; m_stall = 0;
    endtask

    function automatic logic [6:0] word_of(input logic [63:0] pc);
        return 7'((pc / 4) % 128);
    endfunction

    // Drive one cycle of inputs, advance the model by the fetch rules, then move past the edge.
    task automatic step(input logic s, input logic f, input logic p, input logic [63:0] br);
        logic [63:0] npc, nifpc;
        logic [31:0] ninstr;
        logic        nvalid;
        stall = s; flush = f; pcsrc = p; pcbranch = br;
        npc = p ? (br & ~64'd3) : (s ? m_pc : m_pc + 64'd4);
        if (f || p) begin
            ninstr = NOP; nifpc = '0; nvalid = 1'b0;
        end else if (s) begin
            ninstr = m_instr; nifpc = m_ifpc; nvalid = m_valid;
        end else begin
            ninstr = mem[word_of(m_pc)]; nifpc = m_pc; nvalid = 1'b1;
            if (m_fetch < 64'hffffffff) m_fetch++;
        end
        if (s && !p && m_stall < 64'hffffffff) m_stall++;
        @(posedge clk);
        #1;
        m_pc = npc; m_ifpc = nifpc; m_instr = ninstr; m_valid = nvalid;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 0; flush = 0; pcsrc = 0; pcbranch = '0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        total++; if (pc_F !== 64'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_F); end
        total++; if (IF_ID_pc !== 64'd0) begin bad++; $display("FAIL reset_ifpc got=%h exp=0", IF_ID_pc); end
        total++; if (IF_ID_instr !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", IF_ID_instr, NOP); end
        total++; if (IF_ID_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", IF_ID_valid); end
        total++; if (imem_addr !== 7'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            bad++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_stall_cnt); end
`endif
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, '0);
            total++; if (IF_ID_instr !== mem[i]) begin bad++; $display("FAIL seq_instr%0d got=%h exp=%h", i, IF_ID_instr, mem[i]); end
            total++; if (IF_ID_pc !== 64'(4 * i)) begin bad++; $display("FAIL seq_pc%0d got=%h exp=%0d", i, IF_ID_pc, 4 * i); end
            total++; if (IF_ID_valid !== 1'b1) begin bad++; $display("FAIL seq_valid%0d got=%b exp=1", i, IF_ID_valid); end
            total++; if (pc_F !== 64'(4 * i + 4)) begin bad++; $display("FAIL seq_pcF%0d got=%h exp=%0d", i, pc_F, 4 * i + 4); end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, '0);
            total++; if (pc_F !== 64'h10) begin bad++; $display("FAIL stall_pc%0d got=%h exp=10", i, pc_F); end
            total++; if (IF_ID_instr !== mem[3] || IF_ID_pc !== 64'hc || IF_ID_valid !== 1'b1) begin
                bad++; $display("FAIL stall_hold%0d got=%h/%h/%b exp=%h/c/1", i, IF_ID_instr, IF_ID_pc, IF_ID_valid, mem[3]); end
        end
`ifdef FETCH_PERF_CNT_EN
        total++; if (perf_stall_cnt !== 32'd2) begin bad++; $display("FAIL stall_cnt got=%0d exp=2", perf_stall_cnt); end
`endif
        step(0, 0, 0, '0);
        total++; if (pc_F !== 64'h14) begin bad++; $display("FAIL stall_resume got=%h exp=14", pc_F); end
        total++; if (IF_ID_instr !== mem[4] || IF_ID_pc !== 64'h10) begin
            bad++; $display("FAIL stall_resume_ifid got=%h/%h exp=%h/10", IF_ID_instr, IF_ID_pc, mem[4]); end
    endtask

    task automatic test_redirect_stall();
        step(1, 0, 1, 64'h2b);
        total++; if (pc_F !== 64'h28) begin bad++; $display("FAIL redir_pc got=%h exp=28", pc_F); end
        total++; if (IF_ID_instr !== 32'h8b1f03ff) begin bad++; $display("FAIL redir_instr got=%h exp=8b1f03ff", IF_ID_instr); end
        total++; if (IF_ID_valid !== 1'b0 || IF_ID_pc !== 64'd0) begin
            bad++; $display("FAIL redir_ifid got=%b/%h exp=0/0", IF_ID_valid, IF_ID_pc); end
    endtask

    task automatic test_flush();
        step(0, 0, 1, 64'h8);
        step(0, 1, 0, '0);
        total++; if (pc_F !== 64'hc) begin bad++; $display("FAIL flush_pc got=%h exp=c", pc_F); end
        total++; if (IF_ID_instr !== NOP || IF_ID_valid !== 1'b0 || IF_ID_pc !== 64'd0) begin
            bad++; $display("FAIL flush_ifid got=%h/%b/%h exp=%h/0/0", IF_ID_instr, IF_ID_valid, IF_ID_pc, NOP); end
        step(0, 0, 0, '0);
        total++; if (IF_ID_instr !== mem[3] || IF_ID_pc !== 64'hc || IF_ID_valid !== 1'b1) begin
            bad++; $display("FAIL flush_after got=%h/%h/%b exp=%h/c/1", IF_ID_instr, IF_ID_pc, IF_ID_valid, mem[3]); end
    endtask

    task automatic test_wrap();
        step(0, 0, 1, 64'h1fc);
        total++; if (imem_addr !== 7'd127) begin bad++; $display("FAIL wrap_addr_hi got=%0d exp=127", imem_addr); end
        step(0, 0, 0, '0);
        total++; if (pc_F !== 64'h200 || imem_addr !== 7'd0) begin
            bad++; $display("FAIL wrap_addr_lo got=%h/%0d exp=200/0", pc_F, imem_addr); end
        total++; if (IF_ID_instr !== mem[127] || IF_ID_pc !== 64'h1fc) begin
            bad++; $display("FAIL wrap_ifid got=%h/%h exp=%h/1fc", IF_ID_instr, IF_ID_pc, mem[127]); end
    endtask

    task automatic test_async_reset();
        step(0, 0, 1, 64'h40);
        total++; if (pc_F !== 64'h40) begin bad++; $display("FAIL areset_pre got=%h exp=40", pc_F); end
        #3;
        stall = 1; pcsrc = 1; pcbranch = 64'h123;
        reset = 1'b0;
        #1;
        model_reset();
        total++; if (pc_F !== 64'd0 || imem_addr !== 7'd0) begin
            bad++; $display("FAIL areset_pc got=%h/%0d exp=0/0", pc_F, imem_addr); end
        total++; if (IF_ID_instr !== NOP || IF_ID_valid !== 1'b0 || IF_ID_pc !== 64'd0) begin
            bad++; $display("FAIL areset_ifid got=%h/%b/%h exp=%h/0/0", IF_ID_instr, IF_ID_valid, IF_ID_pc, NOP); end
        @(posedge clk); #1;
        total++; if (pc_F !== 64'd0) begin bad++; $display("FAIL areset_hold got=%h exp=0", pc_F); end
        @(negedge clk);
        stall = 0; pcsrc = 0; pcbranch = '0;
        reset = 1'b1;
        step(0, 0, 0, '0);
        total++; if (IF_ID_instr !== mem[0] || IF_ID_pc !== 64'd0 || IF_ID_valid !== 1'b1 || pc_F !== 64'd4) begin
            bad++; $display("FAIL areset_first got=%h/%h/%b/%h exp=%h/0/1/4", IF_ID_instr, IF_ID_pc, IF_ID_valid, pc_F, mem[0]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic s, f, p;
            logic [63:0] br;
            s  = ($urandom_range(3) == 0);
            f  = ($urandom_range(7) == 0);
            p  = ($urandom_range(7) == 0);
            br = {$urandom, $urandom};
            step(s, f, p, br);
            total++; if (pc_F !== m_pc) begin bad++; $display("FAIL rnd_pc%0d got=%h exp=%h", i, pc_F, m_pc); end
            total++; if (imem_addr !== word_of(m_pc)) begin bad++; $display("FAIL rnd_addr%0d got=%0d exp=%0d", i, imem_addr, word_of(m_pc)); end
            total++; if (IF_ID_instr !== m_instr) begin bad++; $display("FAIL rnd_instr%0d got=%h exp=%h", i, IF_ID_instr, m_instr); end
            total++; if (IF_ID_pc !== m_ifpc) begin bad++; $display("FAIL rnd_ifpc%0d got=%h exp=%h", i, IF_ID_pc, m_ifpc); end
            total++; if (IF_ID_valid !== m_valid) begin bad++; $display("FAIL rnd_valid%0d got=%b exp=%b", i, IF_ID_valid, m_valid); end
        end
`ifdef FETCH_PERF_CNT_EN
        total++; if (perf_fetch_cnt !== 32'(m_fetch) || perf_stall_cnt !== 32'(m_stall)) begin
            bad++; $display("FAIL rnd_perf got=%0d/%0d exp=%0d/%0d", perf_fetch_cnt, perf_stall_cnt, m_fetch, m_stall); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_flush();
        test_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter N, default 64, the PC and branch-target width in bits.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h8b1f03ff (ADD XZR,XZR,XZR), the bubble instruction loaded on flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hazard-unit stall; holds PC and IF/ID.
REQ-006 flush  input  1  squashes the IF/ID contents (bubble insert).
REQ-007 PCSrc  input  1  taken-branch redirect request from a later stage.
REQ-008 PCBranch  input  N  redirect target address.
REQ-009 imem_addr  output  7  instruction-memory word address.
REQ-010 imem_q  input  32  instruction word returned combinationally by instruction memory.
REQ-011 pc_F  output  N  current fetch PC.
REQ-012 IF_ID_pc  output  N  PC of the instruction held in IF/ID.
REQ-013 IF_ID_instr  output  32  instruction held in IF/ID.
REQ-014 IF_ID_valid  output  1  IF/ID holds a real fetched instruction.

Function
REQ-015 imem_addr SHALL equal pc_F[8:2], combinationally, with zero-cycle latency.
REQ-016 When PCSrc=1, on the next edge pc_F SHALL load {PCBranch[N-1:2],2'b00}; the low two bits are forced to zero.
REQ-017 When PCSrc=0 and stall=0, on the next edge pc_F SHALL load pc_F+4, modulo 2^N; imem_addr wraps from 127 to 0 naturally.
REQ-018 When PCSrc=0 and stall=1, pc_F SHALL hold.
REQ-019 PCSrc SHALL take priority over stall for pc_F.
REQ-020 When flush=1 or PCSrc=1, on the next edge the IF/ID register SHALL load: instr=NOP_INSTR, pc=0, valid=0.
REQ-021 Flush/redirect SHALL take priority over stall for the IF/ID register.
REQ-022 When no flush or redirect occurs and stall=1, IF/ID SHALL hold all three fields.
REQ-023 Otherwise IF/ID SHALL load instr=imem_q, pc=pc_F, valid=1.
REQ-024 Fetch-to-IF/ID latency SHALL be exactly one cycle.
REQ-025 No combinational path SHALL exist from stall, flush, or PCSrc to any IF_ID_* output.

Reset
REQ-026 While reset=0, all state SHALL clear asynchronously: pc_F=0, IF_ID_pc=0, IF_ID_instr=NOP_INSTR, IF_ID_valid=0, counters=0.
REQ-027 At the first rising edge after reset deasserts, the instruction at address 0 SHALL be captured into IF/ID and pc_F SHALL become 4.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL override all other inputs immediately.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined SHALL add outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0]:
- perf_fetch_cnt increments on each edge where IF/ID loads with valid=1.
- perf_stall_cnt increments on each edge where stall=1 and PCSrc=0.
- Both saturate at 32'hffffffff.
REQ-030 Macro FETCH_PERF_CNT_EN undefined SHALL leave these ports and counters absent, with function otherwise identical.

Verification
REQ-031 Reset release, imem returns words w0..w3, no stall: IF_ID_instr=w0,w1,w2,w3 on consecutive cycles; IF_ID_pc=0,4,8,12; valid=1.
REQ-032 stall held 2 cycles with pc_F=0x10: pc_F stays 0x10 and IF/ID holds; resumes to 0x14 after release; perf_stall_cnt=2 when enabled.
REQ-033 PCSrc=1, PCBranch=0x2B, stall=1 in the same cycle: next pc_F=0x28, IF_ID_instr=0x8b1f03ff, IF_ID_valid=0.
REQ-034 flush=1 alone at pc_F=0x8: IF/ID becomes NOP with valid=0, and pc_F advances to 0xC.
REQ-035 pc_F=0x1FC: imem_addr=127; next cycle pc_F=0x200 and imem_addr=0.
REQ-036 reset pulsed low asynchronously mid-stream at pc_F=0x40: outputs return to reset values before the next clock edge.
